// File: rtl/midi_tx.sv
`default_nettype none
// ============================================================================
// Module   : midi_tx
// Purpose  : Serial MIDI transmitter (8N1, LSB first, idle-high line) with a
//            small byte FIFO fed over a valid/ready handshake.
// Ports    : clk_50m  - system clock, rising edge
//            rst_n    - asynchronous active-low reset
//            in_data  - byte to transmit
//            in_valid - in_data valid this cycle
//            in_ready - FIFO can accept a byte this cycle (= !full)
//            tx       - serial MIDI out, idle high (registered)
//            busy     - frame in progress or FIFO non-empty
// Options  : MIDI_TX_RUNNING_STATUS_EN - drop channel-status bytes that repeat
//            the last transmitted status (MIDI running status).
// Revision : 1.0 - initial release
// ============================================================================
module midi_tx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 31_250,
    parameter int DEPTH  = 4
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    localparam int BIT_TICKS = CLK_HZ / BAUD;
    localparam int TICK_W    = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [ADDR_W:0]   PTR_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;

    // FIFO storage; pointers carry one extra wrap bit to tell full from empty
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;

    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              skip;
    logic              bit_end;
    logic [7:0]        head;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign head     = mem[rd_ptr[ADDR_W-1:0]];
    assign bit_end  = (tick_cnt == TICK_LAST);

    // Bytes leave the FIFO only when the line is free: from IDLE, or on the
    // last tick of a stop bit so back-to-back frames have no idle gap.
    assign pop      = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
    assign busy     = (state != IDLE) || !empty;

`ifdef MIDI_TX_RUNNING_STATUS_EN
    logic [7:0] last_status;
    logic       is_chan_status;

    assign is_chan_status = head[7] && (head[7:4] != 4'hF);
    // last_status only ever holds 0x00 or a channel status, so equality with
    // a channel-status head is the whole running-status test.
    assign skip = is_chan_status && (head == last_status);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk_50m) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'h00;
            tx       <= 1'b1;
            rd_ptr   <= '0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
            last_status <= 8'h00;
`endif
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
`ifdef MIDI_TX_RUNNING_STATUS_EN
                if (!skip) begin
                    if (head[7:4] == 4'hF) begin
                        // System common/exclusive cancels running status;
                        // real-time bytes leave it untouched.
                        if (!head[3]) begin
                            last_status <= 8'h00;
                        end
                    end else if (head[7]) begin
                        last_status <= head;
                    end
                end
`endif
            end

            if (state == IDLE) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= bit_end ? '0 : (tick_cnt + TICK_ONE);
            end

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop && !skip) begin
                        shift <= head;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx      <= shift[0];
                        bit_idx <= 3'd0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (pop && !skip) begin
                            shift <= head;
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            // A suppressed byte returns to IDLE so the next
                            // FIFO entry is evaluated on the following cycle.
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_midi_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_midi_tx
// Purpose  : Directed self-checking bench for midi_tx. Uses a reduced clock
//            (16 clocks per bit) and an 8N1 receiver model on the tx line.
// Options  : MIDI_TX_RUNNING_STATUS_EN selects the running-status expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_midi_tx;

    localparam int BT = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int framing_err = 0;
    bit rx_active = 1'b0;
    bit saw_full  = 1'b0;

    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];

    midi_tx #(
        .CLK_HZ (500_000),
        .BAUD   (31_250),
        .DEPTH  (4)
    ) dut (
        .clk_50m  (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 8N1 receiver: detect start on a falling edge, sample mid-bit
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                repeat (BT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BT) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BT) @(negedge clk);
                if (tx !== 1'b1) framing_err++;
                rx_q.push_back(b);
                rx_active = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        while (rx_active && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        rx_q.delete();
    endtask

    task automatic push(input logic [7:0] b);
        bit ok;
        int n;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            if (!ok) saw_full = 1'b1;
            @(posedge clk);
            n++;
        end while (!ok && n < 2000);
        if (!ok) check("push_timeout", 32'd0, 32'd1);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((busy || rx_active) && n < 20000);
        if (busy || rx_active) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_rx(input string tag);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) check({tag, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int errs;
        int t0;
        logic [9:0] fr;
        logic [7:0] seq [9];

        rst_n    = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_ready", {31'd0, in_ready}, 32'd1);

        // Idle line after reset
        do_reset();
        errs = 0;
        for (int k = 0; k < 5000; k++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) errs++;
        end
        check("idle_errs", errs, 32'd0);

        // Single 0x90 frame with exact bit timing
        do_reset();
        in_data  = 8'h90;
        in_valid = 1'b1;
        @(negedge clk);
        check("ready_before_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("busy_at_accept", {31'd0, busy}, 32'd1);
        check("tx_high_at_accept", {31'd0, tx}, 32'd1);
        fr = {1'b1, 8'h90, 1'b0};
        errs = 0;
        for (int k = 0; k < 10 * BT; k++) begin
            @(posedge clk);
            #1;
            if (tx !== fr[k / BT] || busy !== 1'b1) errs++;
        end
        check("frame_wave_errs", errs, 32'd0);
        @(posedge clk);
        #1;
        check("busy_fall", {31'd0, busy}, 32'd0);
        check("tx_idle_after", {31'd0, tx}, 32'd1);
        exp_q.push_back(8'h90);
        expect_rx("single");

        // Three contiguous frames
        do_reset();
        push(8'h90);
        t0 = cyc;
        push(8'h3C);
        push(8'h64);
        wait_idle();
        check("three_frame_cycles", cyc - t0, 32'd481);
        exp_q.push_back(8'h90);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h64);
        expect_rx("three");

        // Backpressure: 8 bytes into a 4-deep FIFO
        do_reset();
        saw_full = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        check("saw_full", {31'd0, saw_full}, 32'd1);
        wait_idle();
        for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
        expect_rx("fill");

        // Reset mid-frame with bytes queued
        do_reset();
        push(8'h55);
        push(8'hAA);
        push(8'h33);
        repeat (4 * BT) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1 rx_q.delete();
        errs = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        check("post_reset_quiet", errs, 32'd0);
        check("post_reset_frames", rx_q.size(), 32'd0);

        // Running-status sequence
        do_reset();
        seq = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3C, 8'h00, 8'hF8, 8'h90, 8'h40};
        for (int i = 0; i < 9; i++) push(seq[i]);
        wait_idle();
`ifdef MIDI_TX_RUNNING_STATUS_EN
        exp_q.push_back(8'h90);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h64);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hF8);
        exp_q.push_back(8'h40);
`else
        for (int i = 0; i < 9; i++) exp_q.push_back(seq[i]);
`endif
        expect_rx("rs");

        check("framing_errors", framing_err, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/midi_tx.md
Name: midi_tx

Overview:
- Serial MIDI transmitter: 31.25 kbaud, 8N1, LSB first, idle-high line.
- Accepts bytes from the synth's control or MIDI-thru logic over a valid/ready handshake.
- Buffers bytes in a small FIFO and drives the MIDI OUT UART pin.
- Frame format and bit timing match the codebase's MIDI receive path, so a loopback through it recovers every byte.

Parameters:
- CLK_HZ, 50_000_000: system clock frequency in Hz.
- BAUD, 31_250: line bit rate.
- DEPTH, 4: FIFO depth in bytes; must be a power of 2, >= 2.

Ports:
- clk_50m  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  8  byte to transmit.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a byte this cycle.
- tx  output  1  serial MIDI out, idle high.
- busy  output  1  frame in progress or FIFO non-empty.

Behaviour:
- Reset values (applied asynchronously, including mid-frame):
  - tx=1, in_ready=1, busy=0.
  - FIFO emptied, state IDLE, all counters 0.
  - Any partially sent frame is abandoned; the line returns high immediately.
- Bit timing:
  - BIT_TICKS = CLK_HZ/BAUD, integer division (1600 at defaults).
  - Tick counter runs 0..BIT_TICKS-1 inside each bit and is held at 0 in IDLE.
  - Every bit lasts exactly BIT_TICKS cycles; one frame = 10*BIT_TICKS cycles (16000).
- Input handshake:
  - A byte is accepted on a rising edge where in_valid && in_ready.
  - in_ready = !full, derived combinationally from FIFO occupancy.
  - When full, in_valid is ignored and no data is lost or overwritten.
  - in_data must be held stable only in the accepting cycle.
- FIFO:
  - DEPTH entries, read/write pointers 1 bit wider than the address.
  - Push and pop in the same cycle are both allowed when not empty and not full; occupancy is unchanged.
  - Pop happens only in IDLE, or at the end of a stop bit.
- State machine (registered tx):
  - IDLE: tx=1. If FIFO non-empty: pop, load shift register, tx=0, go START. Accept at edge N into an empty FIFO gives tx falling at edge N+1.
  - START: after BIT_TICKS cycles, tx=shift[0], bit index=0, go DATA.
  - DATA: each BIT_TICKS boundary shifts right and drives the next bit. After bit 7 completes: tx=1, go STOP.
  - STOP: after BIT_TICKS cycles, pop if FIFO non-empty and go directly to START with tx=0 (no idle gap). Otherwise go IDLE.
- busy = (state != IDLE) || !empty. It falls on the same edge the stop bit completes with an empty FIFO.
- No parity, single stop bit; BAUD is not adjustable at runtime.

Optional Feature:
- Macro MIDI_TX_RUNNING_STATUS_EN.
- Defined:
  - A register last_status (reset 0x00) applies MIDI running status at pop time.
  - Popped byte in 0x80..0xEF equal to last_status: consumed without a frame. FSM stays or returns to IDLE, and the next pop is evaluated the following cycle.
  - Popped byte in 0x80..0xEF not equal to last_status: sent, and last_status is updated to it.
  - Bytes 0xF0..0xF7: sent, and last_status is cleared to 0x00.
  - Bytes 0xF8..0xFF (real-time): sent, last_status unchanged.
  - Data bytes 0x00..0x7F: always sent.
- Not defined: every accepted byte is transmitted verbatim; no last_status register exists.

Test Plan:
- Reset, then idle 5000 cycles -> tx=1, busy=0, in_ready=1 throughout.
- Push 0x90 at edge N -> tx=0 from edge N+1 for 1600 cycles. Then data bits 0,0,0,0,1,0,0,1 at 1600 cycles each, then stop bit high. busy falls at N+1+16000.
- Push 0x90, 0x3C, 0x64 back-to-back -> three contiguous frames, 48000 cycles total, no idle gap. Loopback through the MIDI receive path yields 0x90, 0x3C, 0x64 in order.
- Hold in_valid for 8 bytes 0x01..0x08 with DEPTH=4 -> in_ready drops when full. All 8 bytes transmitted in order with none dropped or duplicated.
- Assert rst_n low mid-DATA of a 0x55 frame, with 2 bytes queued -> tx=1 immediately, busy=0. After release, no further frames are sent.
- With MIDI_TX_RUNNING_STATUS_EN, push 0x90 0x3C 0x64 0x90 0x3C 0x00 -> wire carries 0x90 0x3C 0x64 0x3C 0x00. Then push 0xF8 0x90 0x40 -> wire carries 0xF8 0x40. Without the macro, all 9 bytes appear on the wire.
